// File: rtl/tpu_pkg.sv
// Shared types and defaults for the systolic array operand feeders.
package tpu_pkg;

  localparam int unsigned BITS_AB_DEF = 8;
  localparam int unsigned DIM_DEF     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } feeder_state_t;

  // Valid beats needed to push a skewed DIM x DIM matrix through the west edge.
  function automatic int unsigned beat_count(input int unsigned dim);
    return 2 * dim - 1;
  endfunction

endpackage

// File: rtl/systolic_a_feeder_lane.sv
// One array row: holds that row's DIM operands and emits the skewed element per beat.
module systolic_a_feeder_lane
  import tpu_pkg::*;
#(
  parameter  int unsigned BITS_AB = BITS_AB_DEF,
  parameter  int unsigned DIM     = DIM_DEF,
  parameter  int unsigned ROW     = 0,
  localparam int unsigned TW      = $clog2(2 * DIM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [DIM*BITS_AB-1:0] wr_data,
  input  logic                   adv,
  input  logic [TW-1:0]          t,
  output logic [BITS_AB-1:0]     lane_out
);

  logic signed [BITS_AB-1:0] mem_q [DIM];
  logic signed [BITS_AB-1:0] mem_d [DIM];
  logic signed [BITS_AB-1:0] out_q;
  logic signed [BITS_AB-1:0] out_d;

  // Row capture and beat selection; beats outside this row's window are exact zero.
  always_comb begin
    mem_d = mem_q;
    out_d = out_q;
    if (wr_en) begin
      for (int k = 0; k < int'(DIM); k++) begin
        mem_d[k] = wr_data[k*BITS_AB +: BITS_AB];
      end
    end
    if (adv) begin
      out_d = '0;
      for (int k = 0; k < int'(DIM); k++) begin
        if (t == TW'(ROW + 32'(k))) out_d = mem_q[k];
      end
    end
  end

  // Row storage and registered lane output, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(DIM); k++) begin
        mem_q[k] <= '0;
      end
      out_q <= '0;
    end else begin
      mem_q <= mem_d;
      out_q <= out_d;
    end
  end

  assign lane_out = out_q;

endmodule

// File: rtl/systolic_a_feeder.sv
// Buffers a DIM x DIM operand matrix and streams it diagonally skewed into the array west edge.
module systolic_a_feeder
  import tpu_pkg::*;
#(
  parameter  int unsigned BITS_AB = BITS_AB_DEF,
  parameter  int unsigned DIM     = DIM_DEF,
  localparam int unsigned AW      = $clog2(DIM),
  localparam int unsigned TW      = $clog2(2 * DIM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_row,
  input  logic [DIM*BITS_AB-1:0] wr_data,
  input  logic                   start,
  input  logic                   stall,
  output logic                   busy,
  output logic                   done,
  output logic                   a_valid,
  output logic [DIM*BITS_AB-1:0] a_out
);

  localparam logic [TW-1:0] LAST_T = TW'(beat_count(DIM) - 1);

  feeder_state_t state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          a_valid_q, a_valid_d;
  logic          adv_c;
  logic          wr_go_c;
  logic [DIM-1:0] lane_we_c;

  // Sequencer: beat counter, state transitions and status outputs.
  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    adv_c     = 1'b0;
    wr_go_c   = 1'b0;
    case (state_q)
      IDLE: begin
        wr_go_c = wr_en && !start;
        if (start) begin
          state_d = STREAM;
          t_d     = '0;
        end
      end
      STREAM: begin
        if (!stall) begin
          adv_c = 1'b1;
          t_d   = t_q + TW'(1);
          if (t_q == LAST_T) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == DONE);
    a_valid_d = adv_c;
  end

  // Row write decode; indices at or above DIM match no lane.
  always_comb begin
    lane_we_c = '0;
    for (int r = 0; r < int'(DIM); r++) begin
      if (wr_go_c && (wr_row == AW'(r))) lane_we_c[r] = 1'b1;
    end
  end

  // Sequencer and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      t_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      a_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      a_valid_q <= a_valid_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign a_valid = a_valid_q;

  for (genvar r = 0; r < int'(DIM); r++) begin : g_lane
    systolic_a_feeder_lane #(
      .BITS_AB (BITS_AB),
      .DIM     (DIM),
      .ROW     (r)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (lane_we_c[r]),
      .wr_data  (wr_data),
      .adv      (adv_c),
      .t        (t_q),
      .lane_out (a_out[r*BITS_AB +: BITS_AB])
    );
  end

endmodule

// File: tb/tb_systolic_a_feeder.sv
// Bench for systolic_a_feeder at DIM=4: random and directed matrices against a matrix model.
module tb_systolic_a_feeder;

  localparam int unsigned BITS = 8;
  localparam int unsigned N    = 4;
  localparam int unsigned W    = N * BITS;
  localparam int          NB   = 2 * N - 1;

  logic         clk;
  logic         rst;
  logic         wr_en;
  logic [1:0]   wr_row;
  logic [W-1:0] wr_data;
  logic         start;
  logic         stall;
  logic         busy;
  logic         done;
  logic         a_valid;
  logic [W-1:0] a_out;

  int           ref_mem [N][N];
  logic [W-1:0] exp_hold;
  int           vectors;
  int           miscompares;

  systolic_a_feeder #(.BITS_AB(BITS), .DIM(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .start   (start),
    .stall   (stall),
    .busy    (busy),
    .done    (done),
    .a_valid (a_valid),
    .a_out   (a_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Skewed beat t of the model matrix: lane r carries element t-r of row r, else zero.
  function automatic logic [W-1:0] exp_beat(input int t);
    logic [W-1:0] v;
    v = '0;
    for (int r = 0; r < int'(N); r++) begin
      int k = t - r;
      if (k >= 0 && k < int'(N)) v[r*BITS +: BITS] = 8'(ref_mem[r][k]);
    end
    return v;
  endfunction

  task automatic load_row(input int r, input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_row  = 2'(r);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    for (int k = 0; k < int'(N); k++) ref_mem[r][k] = int'($signed(d[k*BITS +: BITS]));
  endtask

  task automatic load_random();
    for (int r = 0; r < int'(N); r++) load_row(r, W'($urandom()));
  endtask

  // One full stream with optional stall before the first beat, a stall burst after a beat,
  // and optional row-1 writes during the start cycle and the stream.
  task automatic run_stream(input int pre_stall, input int stall_at, input int stall_len,
                            input bit poke);
    int nb, stall_left, stalled, cycles;
    bit got_done, prev_valid;
    logic [W-1:0] last;
    nb = 0; stalled = 0; cycles = 0; got_done = 0; prev_valid = 0;
    last = exp_hold;
    stall_left = pre_stall;
    start   = 1'b1;
    stall   = (stall_left > 0);
    if (stall_left > 0) stall_left--;
    wr_en   = poke;
    wr_row  = 2'd1;
    wr_data = {N{8'd9}};
    tick();
    start = 1'b0;
    check("busy_on_start", W'(busy), 1);
    check("no_beat_on_start", W'(a_valid), 0);
    for (int c = 0; c < 60 && !got_done; c++) begin
      stall = (stall_left > 0);
      if (stall) begin
        stall_left--;
        stalled++;
      end
      tick();
      cycles++;
      if (a_valid) begin
        check($sformatf("beat%0d", nb), a_out, exp_beat(nb));
        check("busy_in_stream", W'(busy), 1);
        last = exp_beat(nb);
        if (nb == stall_at) stall_left = stall_len;
        nb++;
      end else if (done) begin
        got_done = 1'b1;
        check("done_follows_last", W'(prev_valid), 1);
        check("busy_drop_at_done", W'(busy), 0);
      end else begin
        check("hold_a_out", a_out, last);
        check("busy_hold", W'(busy), 1);
      end
      prev_valid = a_valid;
    end
    wr_en = 1'b0;
    stall = 1'b0;
    exp_hold = last;
    check("done_seen", W'(got_done), 1);
    check("beat_total", W'(nb), W'(NB));
    check("cycle_total", W'(cycles), W'(NB + 1 + stalled));
    tick();
    check("done_one_cycle", W'(done), 0);
    check("idle_valid", W'(a_valid), 0);
  endtask

  initial begin
    int nb;
    vectors = 0; miscompares = 0; exp_hold = '0;
    rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_data = '0; start = 1'b0; stall = 1'b0;

    // Reset state.
    #12;
    check("rst_busy", W'(busy), 0);
    check("rst_done", W'(done), 0);
    check("rst_valid", W'(a_valid), 0);
    check("rst_a_out", a_out, 0);
    rst = 1'b0;
    tick();

    // Counting-pattern matrix, no stalls.
    for (int r = 0; r < int'(N); r++)
      load_row(r, {8'(r*4+3), 8'(r*4+2), 8'(r*4+1), 8'(r*4)});
    run_stream(0, -1, 0, 1'b0);

    // Signed extremes in row 0 plus a three-cycle stall after beat 2.
    load_row(0, {8'h00, 8'hFF, 8'h7F, 8'h80});
    run_stream(0, 2, 3, 1'b0);

    // Writes during start and stream are ignored; re-stream shows the original buffer.
    load_random();
    run_stream(0, -1, 0, 1'b1);
    run_stream(0, -1, 0, 1'b0);

    // Random matrices with varied stall placement, including stall in the start cycle.
    for (int i = 0; i < 3; i++) begin
      load_random();
      run_stream(0, int'($urandom_range(0, 5)), int'($urandom_range(1, 4)), 1'b0);
    end
    load_random();
    run_stream(3, -1, 0, 1'b0);

    // Reset mid-stream after beat 4: immediate clear, no done, buffer zeroed.
    start = 1'b1;
    tick();
    start = 1'b0;
    nb = 0;
    for (int c = 0; c < 20 && nb < 5; c++) begin
      tick();
      if (a_valid) nb++;
    end
    check("rst_pre_beats", W'(nb), 5);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_a_out", a_out, 0);
    check("mid_rst_valid", W'(a_valid), 0);
    check("mid_rst_busy", W'(busy), 0);
    for (int r = 0; r < int'(N); r++)
      for (int k = 0; k < int'(N); k++) ref_mem[r][k] = 0;
    exp_hold = '0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("no_done_after_rst", W'(done), 0);
    end
    run_stream(0, -1, 0, 1'b0);

    // start held high: one stream per IDLE visit, DONE and IDLE cycles between streams.
    load_random();
    start = 1'b1;
    for (int i = 0; i < 18; i++) begin
      bit exp_v, exp_d;
      tick();
      exp_v = (i >= 1 && i <= 7) || (i >= 10 && i <= 16);
      exp_d = (i == 8) || (i == 17);
      check($sformatf("b2b_valid%0d", i), W'(a_valid), W'(exp_v));
      check($sformatf("b2b_done%0d", i), W'(done), W'(exp_d));
      check($sformatf("b2b_busy%0d", i), W'(busy), W'(!exp_d));
      if (exp_v) check($sformatf("b2b_beat%0d", i), a_out, exp_beat(i <= 7 ? i - 1 : i - 10));
    end
    start = 1'b0;
    tick();
    check("b2b_end_busy", W'(busy), 0);
    check("b2b_end_valid", W'(a_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
